// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-stage <-> divide sequencer bundle.
// master = EX stage / HI-LO side, slave = div_ctrl.
// Optional DIV_CANCEL_EN adds the pipeline-flush input.
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
`ifdef DIV_CANCEL_EN
    logic                 cancel;
`endif
    logic                 stall_o;
    logic                 ready;
    logic                 hilo_we;
    logic [2*WIDTH-1:0]   result;

`ifdef DIV_CANCEL_EN
    modport master (
        output start, signed_div, a, b, cancel,
        input  stall_o, ready, hilo_we, result
    );
    modport slave (
        input  start, signed_div, a, b, cancel,
        output stall_o, ready, hilo_we, result
    );
`else
    modport master (
        output start, signed_div, a, b,
        input  stall_o, ready, hilo_we, result
    );
    modport slave (
        input  start, signed_div, a, b,
        output stall_o, ready, hilo_we, result
    );
`endif
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider sequencer for the HI/LO path.
// Runs WIDTH radix-2 steps on operand magnitudes, fixes signs at the end,
// and writes {remainder, quotient} with a one-cycle hilo_we pulse.
// Optional feature macro: DIV_CANCEL_EN (adds a pipeline-flush cancel input).
//
// state  | meaning
// IDLE   | waiting for start; stall asserted combinationally on start
// ZERO   | divide by zero; load {a, all-ones}
// BUSY   | one restoring step per cycle, WIDTH steps
// DONE   | result valid, ready/hilo_we pulse, stall released
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_BUSY, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 stall_w, ready_w, cancel_w;
    logic [WIDTH:0]       part, trial;
    logic [WIDTH-1:0]     rem_step, quo_step;
    logic [WIDTH-1:0]     a_mag, b_mag;

`ifdef DIV_CANCEL_EN
    assign cancel_w = bus.cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // One restoring step: the remainder gets an extra top bit so the trial
    // subtract is correct even for divisors with the MSB set.
    assign part     = {rem_q, quo_q[WIDTH-1]};
    assign trial    = part - {1'b0, dvs_q};
    assign rem_step = trial[WIDTH] ? part[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    // Operand magnitudes; wraparound makes |0x80..0| = 0x80..0.
    assign a_mag = (bus.signed_div && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign b_mag = (bus.signed_div && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state, datapath update and outputs.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        stall_w  = 1'b0;
        ready_w  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !cancel_w) begin
                    stall_w = 1'b1;
                    negq_d  = bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    negr_d  = bus.signed_div & bus.a[WIDTH-1];
                    cnt_d   = '0;
                    rem_d   = '0;
                    dvs_d   = b_mag;
                    if (bus.b == '0) begin
                        // raw dividend kept for the {a, all-ones} result
                        quo_d   = bus.a;
                        state_d = S_ZERO;
                    end else begin
                        quo_d   = a_mag;
                        state_d = S_BUSY;
                    end
                end
            end
            S_ZERO: begin
                stall_w  = 1'b1;
                result_d = {quo_q, {WIDTH{1'b1}}};
                state_d  = S_DONE;
            end
            S_BUSY: begin
                stall_w = 1'b1;
                rem_d   = rem_step;
                quo_d   = quo_step;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = {negr_q ? (~rem_step + 1'b1) : rem_step,
                                negq_q ? (~quo_step + 1'b1) : quo_step};
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                ready_w = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cancel_w) begin
            state_d  = S_IDLE;
            result_d = result_q;
            ready_w  = 1'b0;
        end
    end

    assign bus.stall_o = stall_w;
    assign bus.ready   = ready_w;
    assign bus.hilo_we = ready_w;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed test of the divide sequencer with a result scoreboard.
module tb_div_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_ctrl_if #(.WIDTH(W)) bus ();
    div_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;
    logic [2*W-1:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one divide, hold start until DONE, check stall/latency/result.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp, input int lat);
        int n;
        sb_q.push_back(exp);
        bus.a = a;
        bus.b = b;
        bus.signed_div = sgn;
        bus.start = 1'b1;
        #1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            check({tag, "_stall"}, 64'(bus.stall_o), 64'd1);
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_ready"}, 64'(bus.ready), 64'd1);
        check({tag, "_hilo_we"}, 64'(bus.hilo_we), 64'd1);
        check({tag, "_stall_done"}, 64'(bus.stall_o), 64'd0);
        if (sb_q.size() > 0) check({tag, "_result"}, bus.result, sb_q.pop_front());
        step();
        bus.start = 1'b0;
        #1;
        check({tag, "_post_stall"}, 64'(bus.stall_o), 64'd0);
        check({tag, "_post_ready"}, 64'(bus.ready), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic        seen;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef DIV_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        step();
        step();
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_hilo_we", 64'(bus.hilo_we), 64'd0);
        check("rst_result", bus.result, 64'd0);
        rst = 1'b0;
        step();

        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33);
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
        run_div("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 33);
        run_div("div_zero", 32'd5, 32'd0, 1'b0, {32'h5, 32'hFFFF_FFFF}, 2);
        run_div("divu_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, {32'h7FFF_FFFE, 32'h1}, 33);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            rs = i[0] ^ i[1];
            if (rb == 0) rb = 32'd1;
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            run_div("rand", ra, rb, rs, model(ra, rb, rs), 33);
        end

        // Reset in the middle of a divide.
        bus.a = 32'd1000;
        bus.b = 32'd3;
        bus.signed_div = 1'b0;
        bus.start = 1'b1;
        #1;
        repeat (10) step();
        rst = 1'b1;
        bus.start = 1'b0;
        step();
        check("rst_mid_stall", 64'(bus.stall_o), 64'd0);
        check("rst_mid_result", bus.result, 64'd0);
        check("rst_mid_ready", 64'(bus.ready), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.ready === 1'b1 || bus.hilo_we === 1'b1) seen = 1'b1;
        end
        check("rst_mid_no_ready", 64'(seen), 64'd0);

`ifdef DIV_CANCEL_EN
        run_div("divu_50_5", 32'd50, 32'd5, 1'b0, {32'h0, 32'd10}, 33);
        bus.a = 32'd77;
        bus.b = 32'd4;
        bus.start = 1'b1;
        #1;
        repeat (5) step();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        bus.start = 1'b0;
        #1;
        check("cancel_stall", 64'(bus.stall_o), 64'd0);
        check("cancel_result", bus.result, {32'h0, 32'd10});
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.ready === 1'b1 || bus.hilo_we === 1'b1) seen = 1'b1;
        end
        check("cancel_no_we", 64'(seen), 64'd0);

        bus.start = 1'b1;
        bus.cancel = 1'b1;
        #1;
        check("cancel_prio_stall", 64'(bus.stall_o), 64'd0);
        step();
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        #1;
        check("cancel_prio_idle", 64'(bus.stall_o), 64'd0);

        bus.a = 32'd1;
        bus.b = 32'd0;
        bus.start = 1'b1;
        #1;
        step();
        step();
        bus.cancel = 1'b1;
        #1;
        check("cancel_done_ready", 64'(bus.ready), 64'd0);
        check("cancel_done_we", 64'(bus.hilo_we), 64'd0);
        step();
        bus.cancel = 1'b0;
        bus.start = 1'b0;
        step();

        run_div("divu_9_3", 32'd9, 32'd3, 1'b0, {32'h0, 32'd3}, 33);
`endif

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
